// File: rtl/multdiv_param.sv
// Iterative multiply/divide unit: radix-4 Booth multiplier and non-restoring divider
// sharing one control FSM, with a one-cycle completion pulse and abort-on-restart.
module multdiv_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_SIGNED,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_resultHI,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  localparam int PW = 2 * WIDTH;
  localparam int RW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] MUL_LAST     = CW'(WIDTH / 2);
  localparam logic [CW-1:0] DIV_ITER_END = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} stateT;

  stateT            state;
  logic [CW-1:0]    count;
  logic             signedMode;
  logic [WIDTH-1:0] opA, opB;

  logic [PW-1:0]    mulAcc, mulCand;
  logic [WIDTH+1:0] mulPlier;
  logic             mulPrev;

  logic [RW-1:0]    divRem;
  logic [WIDTH-1:0] divQ, divD;

  // Booth digit selection and accumulate; the product is only needed modulo 2^(2*WIDTH).
  logic [2:0]       boothBits;
  logic [PW-1:0]    partial, mulSum;
  logic [WIDTH-1:0] mulLo, mulHi;
  logic             mulExc;

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    boothBits = {mulPlier[1:0], mulPrev};
    partial   = '0;
    case (boothBits)
      3'b001, 3'b010: partial = mulCand;
      3'b011:         partial = mulCand << 1;
      3'b100:         partial = -(mulCand << 1);
      3'b101, 3'b110: partial = -mulCand;
      default:        partial = '0;
    endcase
    mulSum = mulAcc + partial;
    mulLo  = mulSum[WIDTH-1:0];
    mulHi  = mulSum[PW-1:WIDTH];
    mulExc = signedMode ? (mulHi != {WIDTH{mulLo[WIDTH-1]}}) : (mulHi != '0);
  end

  logic             aNeg, bNeg, divByZero, divOverflow;
  logic [WIDTH-1:0] aMag, bMag, remLow, quotOut, remOut;
  logic [RW-1:0]    remShift, remStep;
  logic [WIDTH-1:0] qStep;

  always_comb begin
    aNeg     = signedMode & opA[WIDTH-1];
    bNeg     = signedMode & opB[WIDTH-1];
    aMag     = aNeg ? -opA : opA;
    bMag     = bNeg ? -opB : opB;
    remShift = {divRem[WIDTH:0], divQ[WIDTH-1]};
    remStep  = divRem[RW-1] ? remShift + {2'b00, divD} : remShift - {2'b00, divD};
    qStep    = {divQ[WIDTH-2:0], ~remStep[RW-1]};
    // Final partial remainder lies in [0, divisor), so WIDTH bits are enough for the restore.
    remLow   = divRem[RW-1] ? divRem[WIDTH-1:0] + divD : divRem[WIDTH-1:0];
    quotOut  = (aNeg ^ bNeg) ? -divQ : divQ;
    remOut   = aNeg ? -remLow : remLow;
    divByZero   = (opB == '0);
    divOverflow = signedMode && (opA == {1'b1, {(WIDTH-1){1'b0}}}) && (opB == '1);
  end

  // NOTE: synchronous reset clears every register, datapath included, so no stale operand
  // or partial result survives an abort.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      signedMode     <= 1'b0;
      opA            <= '0;
      opB            <= '0;
      mulAcc         <= '0;
      mulCand        <= '0;
      mulPlier       <= '0;
      mulPrev        <= 1'b0;
      divRem         <= '0;
      divQ           <= '0;
      divD           <= '0;
      data_result    <= '0;
      data_resultHI  <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        state      <= ctrl_MULT ? MULT : DIV;
        count      <= '0;
        data_busy  <= 1'b0;
        signedMode <= ctrl_SIGNED;
        opA        <= data_operandA;
        opB        <= data_operandB;
        mulAcc     <= '0;
        mulCand    <= {{(PW-WIDTH){ctrl_SIGNED & data_operandA[WIDTH-1]}}, data_operandA};
        mulPlier   <= {{2{ctrl_SIGNED & data_operandB[WIDTH-1]}}, data_operandB};
        mulPrev    <= 1'b0;
        divRem     <= '0;
        divQ       <= '0;
        divD       <= '0;
      end else begin
        unique case (state)
          MULT: begin
            mulAcc   <= mulSum;
            mulCand  <= mulCand << 2;
            mulPlier <= mulPlier >> 2;
            mulPrev  <= mulPlier[1];
            count    <= count + 1'b1;
            if (count == MUL_LAST) begin
              state          <= DONE;
              data_resultRDY <= 1'b1;
              data_busy      <= 1'b0;
              data_result    <= mulLo;
              data_resultHI  <= mulHi;
              data_exception <= mulExc;
            end else begin
              data_busy <= 1'b1;
            end
          end
          DIV: begin
            count <= count + 1'b1;
            if (count == '0) begin
              divQ      <= aMag;
              divD      <= bMag;
              divRem    <= '0;
              data_busy <= 1'b1;
            end else if (count <= DIV_ITER_END) begin
              divRem    <= remStep;
              divQ      <= qStep;
              data_busy <= 1'b1;
            end else begin
              state          <= DONE;
              data_resultRDY <= 1'b1;
              data_busy      <= 1'b0;
              if (divByZero) begin
                data_result    <= '0;
                data_resultHI  <= '0;
                data_exception <= 1'b1;
              end else if (divOverflow) begin
                data_result    <= {1'b1, {(WIDTH-1){1'b0}}};
                data_resultHI  <= '0;
                data_exception <= 1'b1;
              end else begin
                data_result    <= quotOut;
                data_resultHI  <= remOut;
                data_exception <= 1'b0;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_param.sv
// Bench for multdiv_param (WIDTH = 32): transaction-level arithmetic model checked every
// cycle, plus directed vectors with hand-computed literal results and latencies.
module tb_multdiv_param;

  localparam int W = 32;
  localparam int LMUL = W / 2 + 1;
  localparam int LDIV = W + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  data_operandA = '0, data_operandB = '0;
  logic          ctrl_MULT = 1'b0, ctrl_DIV = 1'b0, ctrl_SIGNED = 1'b0;
  logic [W-1:0]  data_result, data_resultHI;
  logic          data_exception, data_resultRDY, data_busy;

  always #5 clock = ~clock;

  multdiv_param #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .ctrl_SIGNED(ctrl_SIGNED),
    .data_result(data_result), .data_resultHI(data_resultHI),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .data_busy(data_busy)
  );

  int testsRun = 0;
  int testsFailed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {exception, hi, lo}.
  function automatic logic [64:0] refMul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint pa, pb, p;
    longint unsigned up;
    logic exc;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({32'h0, a});
      pb = longint'({32'h0, b});
    end
    p  = pa * pb;
    up = p;
    if (s) exc = (p < -64'sd2147483648) || (p > 64'sd2147483647);
    else   exc = (up > 64'hFFFF_FFFF);
    return {exc, p};
  endfunction

  function automatic logic [64:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'h0) return {1'b1, 64'h0};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h0, 32'h8000_0000};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Model: outputs change only on completion; start restarts, reset clears everything.
  bit         modelValid = 1'b0;
  bit         active = 1'b0;
  int         edgeNo = 0, lat = 0;
  logic [64:0] pend = '0;
  logic [31:0] expRes = '0, expHi = '0;
  logic        expExc = 1'b0, expRdy = 1'b0, expBusy = 1'b0;

  task automatic modelStep();
    if (reset) begin
      modelValid = 1'b1;
      active = 1'b0;
      {expExc, expHi, expRes} = '0;
      expRdy = 1'b0;
      expBusy = 1'b0;
    end else begin
      expRdy = 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        pend    = ctrl_MULT ? refMul(data_operandA, data_operandB, ctrl_SIGNED)
                            : refDiv(data_operandA, data_operandB, ctrl_SIGNED);
        lat     = ctrl_MULT ? LMUL : LDIV;
        edgeNo  = 0;
        active  = 1'b1;
        expBusy = 1'b0;
      end else if (active) begin
        edgeNo++;
        if (edgeNo == lat) begin
          {expExc, expHi, expRes} = pend;
          expRdy  = 1'b1;
          expBusy = 1'b0;
          active  = 1'b0;
        end else begin
          expBusy = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    modelStep();
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (modelValid) begin
      check("cyc rdy", 64'(data_resultRDY), 64'(expRdy));
      check("cyc busy", 64'(data_busy), 64'(expBusy));
      check("cyc result", 64'(data_result), 64'(expRes));
      check("cyc resultHI", 64'(data_resultHI), 64'(expHi));
      check("cyc exception", 64'(data_exception), 64'(expExc));
    end
  end

  task automatic startOp(input logic m, input logic d, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; ctrl_SIGNED = s;
    data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
  endtask

  // Counts edges after the accepting edge until the RDY pulse, bounded by maxEdges.
  task automatic waitRdy(input int maxEdges, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < maxEdges) begin
      @(posedge clock);
      #1;
      n++;
      if (data_resultRDY) found = 1'b1;
    end
    if (!found) check("rdy timeout", 64'(found), 64'd1);
  endtask

  task automatic checkOut(input string tag, input logic [31:0] r, input logic [31:0] h, input logic e);
    check({tag, " result"}, 64'(data_result), 64'(r));
    check({tag, " HI"}, 64'(data_resultHI), 64'(h));
    check({tag, " exception"}, 64'(data_exception), 64'(e));
  endtask

  typedef struct {
    logic        m;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
  } vecT;

  vecT vecs [9];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rdyCount;
    int busyCount;

    repeat (2) @(negedge clock);
    checkOut("reset", 32'h0, 32'h0, 1'b0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(data_busy), 64'd0);
    reset = 1'b0;

    startOp(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD);
    waitRdy(60, n);
    check("smul latency", 64'(n), 64'd17);
    checkOut("smul", 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    @(posedge clock); #1;
    check("smul rdy one cycle", 64'(data_resultRDY), 64'd0);

    startOp(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000);
    waitRdy(60, n);
    checkOut("umul ovf", 32'h0, 32'h1, 1'b1);
    startOp(1'b1, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000);
    waitRdy(60, n);
    check("smul ovf exception", 64'(data_exception), 64'd1);

    startOp(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    waitRdy(60, n);
    check("sdiv latency", 64'(n), 64'd34);
    checkOut("sdiv", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    startOp(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    waitRdy(60, n);
    checkOut("udiv", 32'h7FFF_FFFC, 32'h1, 1'b0);

    startOp(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    waitRdy(60, n);
    check("div0 latency", 64'(n), 64'd34);
    checkOut("div0", 32'h0, 32'h0, 1'b1);
    startOp(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitRdy(60, n);
    checkOut("sdiv ovf", 32'h8000_0000, 32'h0, 1'b1);

    // Divide aborted by a multiply accepted at edge 10.
    startOp(1'b0, 1'b1, 1'b0, 32'd1000, 32'd7);
    repeat (9) @(posedge clock);
    startOp(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0100);
    waitRdy(60, n);
    check("restart latency", 64'(n), 64'd17);
    checkOut("restart mul", 32'h0012_3400, 32'h0, 1'b0);
    rdyCount = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdyCount++;
    end
    check("aborted div rdy", 64'(rdyCount), 64'd0);

    startOp(1'b1, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD);
    waitRdy(60, n);
    check("both latency", 64'(n), 64'd17);
    checkOut("both", 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);

    // Reset at edge 5 of a divide, with a start presented on the same edge.
    startOp(1'b0, 1'b1, 1'b0, 32'd99, 32'd4);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1; ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd3;
    @(posedge clock); #1;
    checkOut("midreset", 32'h0, 32'h0, 1'b0);
    check("midreset busy", 64'(data_busy), 64'd0);
    check("midreset rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    reset = 1'b0; ctrl_MULT = 1'b0;
    rdyCount = 0;
    busyCount = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdyCount++;
      if (data_busy) busyCount++;
    end
    check("postreset rdy", 64'(rdyCount), 64'd0);
    check("postreset busy", 64'(busyCount), 64'd0);

    vecs[0] = '{1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[3] = '{1'b1, 1'b1, 32'hFFFF_8000, 32'h0001_0000};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE};
    vecs[6] = '{1'b0, 1'b1, 32'h8000_0000, 32'd3};
    vecs[7] = '{1'b0, 1'b0, 32'd3, 32'd7};
    vecs[8] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE};
    foreach (vecs[i]) begin
      startOp(vecs[i].m, !vecs[i].m, vecs[i].s, vecs[i].a, vecs[i].b);
      waitRdy(60, n);
      check($sformatf("vec%0d latency", i), 64'(n), vecs[i].m ? 64'(LMUL) : 64'(LDIV));
    end
    repeat (3) @(posedge clock);

    #2;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
